muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_start  input  1  EX holds a valid M-extension instruction.
REQ-005 SHALL have port i_op  input  3  muldiv_op_t: mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
REQ-006 SHALL have port i_a, i_b  input  32 each  forwarded rs1/rs2 operands.
REQ-007 SHALL have port i_kill  input  1  branch flush of EX; abandons the operation in flight.
REQ-008 SHALL have port i_hold  input  1  external pipeline stall (memory stage) blocking EX register latch.
REQ-009 SHALL have port o_stall  output  1  forces the EX stage register write enable low.
REQ-010 SHALL have port o_done  output  1  result valid this cycle.
REQ-011 SHALL have port o_result  output  32  result for the EX alu_out mux.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 IDLE: on i_start & !i_kill, SHALL capture operand magnitudes, sign flags and op; go to CALC, or to DONE on the fast path (REQ-018/019).
REQ-014 CALC: SHALL run one radix-2 iteration per cycle (shift-add multiply / restoring divide), 6-bit counter 0..31; after count 31 go to DONE.
REQ-015 Latency: start seen in cycle T, CALC T+1..T+32, DONE from T+33; fast path DONE at T+1.
REQ-016 DONE: o_done=1, o_result stable; stay while i_hold=1; return to IDLE when i_hold=0; i_start ignored in DONE.
REQ-017 o_stall SHALL be combinational: (IDLE & i_start & !i_kill) | CALC; 0 in DONE so EX latches the result.
REQ-018 Divide by zero SHALL take the fast path: div/divu quotient = 0xFFFFFFFF, rem/remu = i_a.
REQ-019 Signed overflow (div/rem, i_a = 0x80000000, i_b = 0xFFFFFFFF) SHALL take the fast path: quotient 0x80000000, remainder 0.
REQ-020 Signed ops SHALL compute on magnitudes and negate at DONE: product if sign(a)^sign(b); quotient likewise; remainder takes sign of dividend. mulhsu treats i_b as unsigned.
REQ-021 mul SHALL return product[31:0]; mulh/mulhsu/mulhu SHALL return product[63:32] of the 64-bit two's-complement result.
REQ-022 i_kill in any state SHALL return to IDLE next cycle, o_done=0 that cycle, no result produced; i_kill overrides i_start.
REQ-023 o_result SHALL be 0 whenever o_done=0.

Reset
REQ-024 rst SHALL force state IDLE, counter 0, all operand/accumulator registers 0, o_done=0, o_result=0, o_stall=0 (when i_start=0).
REQ-025 rst mid-CALC SHALL abandon the operation; first cycle after rst behaves as IDLE.

Structure
REQ-026 muldiv_op_t and the FSM state enum SHALL live in rv32i_types; muldiv_ctrl imports it.
REQ-027 The iterative datapath (64-bit accumulator, shift-add/shift-subtract step) SHALL be one sub-module, muldiv_iter; the FSM, counter, fast-path detection and sign fix-up stay in muldiv_ctrl.
REQ-028 Decode SHALL add an aluout_mux select for muldiv; EX stage ANDs its register write enable with !o_stall.

Verification
REQ-029 mul 7 x -3 (0x00000007, 0xFFFFFFFD) -> o_stall 33 cycles, o_done at T+33, o_result 0xFFFFFFEB.
REQ-030 mulhu 0xFFFFFFFF x 0xFFFFFFFF -> o_result 0xFFFFFFFE; mulh same operands -> 0x00000000.
REQ-031 div -7 / 2 -> 0xFFFFFFFD; rem -7 / 2 -> 0xFFFFFFFF; divu 100 / 0 -> 0xFFFFFFFF at T+1.
REQ-032 div 0x80000000 / 0xFFFFFFFF -> o_done at T+1, o_result 0x80000000; rem same -> 0.
REQ-033 i_kill at T+10 during divu -> IDLE at T+11, o_done never asserted; new i_start at T+11 accepted.
REQ-034 i_hold=1 for 5 cycles upon DONE -> o_done and o_result held 5 cycles, IDLE after i_hold falls; back-to-back i_start accepted the following cycle.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the RV32 M-extension multiply/divide unit.
//   muldiv_op_t    : operation code, encoded as the RISC-V funct3 field
//   muldiv_state_t : control FSM states of muldiv_ctrl
// The helper functions classify an op so decode logic never needs to
// know the encoding.
package rv32i_types;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_DONE
  } muldiv_state_t;

  function automatic logic md_is_div(input muldiv_op_t op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic md_is_rem(input muldiv_op_t op);
    return op inside {MD_REM, MD_REMU};
  endfunction

  // Operand a is signed for mulh, mulhsu, div and rem.
  function automatic logic md_signed_a(input muldiv_op_t op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  // Operand b is signed for mulh, div and rem (mulhsu keeps b unsigned).
  function automatic logic md_signed_b(input muldiv_op_t op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-stage <-> multiply/divide unit handshake.
//   i_start  : EX holds a valid M-extension instruction
//   i_op     : operation (muldiv_op_t)
//   i_a/i_b  : forwarded rs1/rs2 operands
//   i_kill   : branch flush of EX, abandons the operation in flight
//   i_hold   : external stall blocking the EX register latch
//   o_stall  : forces the EX stage register write enable low
//   o_done   : o_result is valid this cycle
//   o_result : result for the EX alu_out mux
// master = EX stage, slave = muldiv_ctrl.
interface muldiv_ctrl_if
  import rv32i_types::*;
#(
  parameter int XLEN = 32
);

  logic            i_start;
  muldiv_op_t      i_op;
  logic [XLEN-1:0] i_a;
  logic [XLEN-1:0] i_b;
  logic            i_kill;
  logic            i_hold;
  logic            o_stall;
  logic            o_done;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_start, i_op, i_a, i_b, i_kill, i_hold,
    input  o_stall, o_done, o_result
  );

  modport slave (
    input  i_start, i_op, i_a, i_b, i_kill, i_hold,
    output o_stall, o_done, o_result
  );

endinterface

// File: rtl/muldiv_iter.sv
// Radix-2 iterative datapath shared by multiply and divide.
//   clk, rst  : clock, synchronous active-high reset
//   i_load    : capture operand magnitudes (acc = {0, i_a}, divisor/multiplicand = i_b)
//   i_step    : perform one iteration
//   i_is_div  : 1 = restoring divide step, 0 = shift-add multiply step
//   i_a, i_b  : unsigned operand magnitudes
//   o_acc     : 64-bit accumulator; after 32 steps holds the product, or
//               {remainder, quotient} for a divide
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_is_div,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic [2*XLEN-1:0] o_acc
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN:0]     add_sum;   // high half + multiplicand, with carry
  logic [XLEN:0]     rem_sh;    // partial remainder shifted left by one
  logic [XLEN-1:0]   rem_sub;   // fits in XLEN bits whenever rem_sh >= b

  // NOTE: every variable assigned here gets a default first, so no path
  // through the block can leave a value unassigned and infer a latch.
  always_comb begin
    acc_d   = acc_q;
    b_d     = b_q;
    add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
    rem_sh  = acc_q[2*XLEN-1:XLEN-1];
    rem_sub = rem_sh[XLEN-1:0] - b_q;

    if (i_load) begin
      acc_d = {{XLEN{1'b0}}, i_a};
      b_d   = i_b;
    end else if (i_step) begin
      if (i_is_div) begin
        // Restoring divide: shift in the next dividend bit, subtract if it fits.
        if (rem_sh >= {1'b0, b_q}) begin
          acc_d = {rem_sub, acc_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[2*XLEN-2:0], 1'b0};
        end
      end else begin
        // Shift-add multiply: the multiplier sits in the low half and is
        // consumed LSB first while the product grows in from the top.
        if (acc_q[0]) begin
          acc_d = {add_sum, acc_q[XLEN-1:1]};
        end else begin
          acc_d = {1'b0, acc_q[2*XLEN-1:1]};
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
    end
  end

  assign o_acc = acc_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32 M-extension multiply/divide controller.
//   clk, rst : clock, synchronous active-high reset
//   bus      : muldiv_ctrl_if.slave (start/op/operands/kill/hold in,
//              stall/done/result out)
// Signed ops run on magnitudes in muldiv_iter for 32 cycles and the sign
// is fixed up in DONE. Divide by zero and signed overflow bypass the
// datapath and reach DONE one cycle after start. The EX stage ANDs its
// register write enable with !o_stall and selects o_result on alu_out.
module muldiv_ctrl
  import rv32i_types::*;
#(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_ctrl_if.slave bus
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  muldiv_op_t        op_q, op_d;
  logic              neg_q, neg_d;        // negate the magnitude result in DONE
  logic              fast_q, fast_d;      // result comes from fast_res_q
  logic [XLEN-1:0]   fast_res_q, fast_res_d;

  logic              load, step, stall, done;
  logic [XLEN-1:0]   result;
  logic              sign_a, sign_b, div_zero, overflow;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] acc, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .i_load   (load),
    .i_step   (step),
    .i_is_div (md_is_div(op_q)),
    .i_a      (a_mag),
    .i_b      (b_mag),
    .o_acc    (acc)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    op_d       = op_q;
    neg_d      = neg_q;
    fast_d     = fast_q;
    fast_res_d = fast_res_q;
    load       = 1'b0;
    step       = 1'b0;
    stall      = 1'b0;
    done       = 1'b0;
    result     = '0;

    sign_a   = md_signed_a(bus.i_op) & bus.i_a[XLEN-1];
    sign_b   = md_signed_b(bus.i_op) & bus.i_b[XLEN-1];
    a_mag    = sign_a ? -bus.i_a : bus.i_a;
    b_mag    = sign_b ? -bus.i_b : bus.i_b;
    div_zero = md_is_div(bus.i_op) && (bus.i_b == '0);
    overflow = (bus.i_op inside {MD_DIV, MD_REM}) && (bus.i_a == INT_MIN) && (bus.i_b == '1);

    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

    case (state_q)
      MD_IDLE: begin
        if (bus.i_start && !bus.i_kill) begin
          stall      = 1'b1;
          load       = 1'b1;
          op_d       = bus.i_op;
          // Remainder follows the dividend; product and quotient follow a^b.
          neg_d      = md_is_rem(bus.i_op) ? sign_a : (sign_a ^ sign_b);
          fast_d     = div_zero | overflow;
          if (div_zero) begin
            fast_res_d = md_is_rem(bus.i_op) ? bus.i_a : '1;
          end else begin
            fast_res_d = md_is_rem(bus.i_op) ? '0 : INT_MIN;
          end
          state_d    = (div_zero | overflow) ? MD_DONE : MD_CALC;
        end
      end
      MD_CALC: begin
        stall = 1'b1;
        step  = 1'b1;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = MD_DONE;
      end
      MD_DONE: begin
        done = 1'b1;
        if (fast_q) begin
          result = fast_res_q;
        end else begin
          case (op_q)
            MD_MUL:                      result = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:             result = quo_fix;
            default:                     result = rem_fix;
          endcase
        end
        if (!bus.i_hold) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase

    // A flush discards whatever is in flight, including a result that
    // would otherwise be presented this cycle.
    if (bus.i_kill) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
      done    = 1'b0;
      result  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      op_q       <= MD_MUL;
      neg_q      <= 1'b0;
      fast_q     <= 1'b0;
      fast_res_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      neg_q      <= neg_d;
      fast_q     <= fast_d;
      fast_res_q <= fast_res_d;
    end
  end

  assign bus.o_stall  = stall;
  assign bus.o_done   = done;
  assign bus.o_result = result;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl. A driver issues operations and
// pushes the expected result, latency and DONE length into a queue; a
// monitor on the falling edge pops and compares whenever o_done rises.
module tb_muldiv_ctrl;
  import rv32i_types::*;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef struct {
    logic [31:0] res;
    int          lat;    // cycles from start to first o_done (= stall cycles)
    int          start;  // cycle in which i_start was driven
    int          len;    // number of cycles o_done stays high
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  muldiv_ctrl_if #(.XLEN(32)) bus ();

  muldiv_ctrl #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic ref_fast(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    if (op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU} && b == 32'd0) return 1'b1;
    if (op inside {MD_DIV, MD_REM} && a == INT_MIN && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_result(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint          ub = {32'd0, b};
    longint unsigned ua = {32'd0, a};
    longint unsigned uu = {32'd0, b};
    longint          p;
    longint unsigned pu;
    int              ia = $signed(a);
    int              ib = $signed(b);
    case (op)
      MD_MUL:    begin pu = ua * uu; return pu[31:0];  end
      MD_MULH:   begin p  = sa * sb; return p[63:32];  end
      MD_MULHSU: begin p  = sa * ub; return p[63:32];  end
      MD_MULHU:  begin pu = ua * uu; return pu[63:32]; end
      MD_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == INT_MIN && b == 32'hFFFF_FFFF) return INT_MIN;
        return ia / ib;
      end
      MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MD_REM: begin
        if (b == 0) return a;
        if (a == INT_MIN && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1 with the DUT idle. hold_n = DONE cycles with i_hold=1,
  // so o_done stays high for hold_n + 1 cycles. i_start is pulsed with junk
  // operands while held in DONE; it must be ignored.
  task automatic do_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b, input int hold_n);
    exp_t e;
    int   k;
    e.res   = ref_result(op, a, b);
    e.lat   = ref_fast(op, a, b) ? 1 : 33;
    e.start = cyc;
    e.len   = hold_n + 1;
    exp_q.push_back(e);
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_hold  = 1'b0;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    k = 0;
    while (!bus.o_done && k < 64) begin
      @(posedge clk); #1;
      k++;
    end
    check("done_seen", {31'd0, bus.o_done}, 32'd1);
    if (!bus.o_done) begin
      exp_q.delete();
      return;
    end
    bus.i_hold = (hold_n > 0);
    repeat (hold_n) begin
      bus.i_start = 1'b1;
      bus.i_op    = muldiv_op_t'(3'($urandom_range(0, 7)));
      bus.i_a     = $urandom;
      bus.i_b     = $urandom;
      @(posedge clk); #1;
    end
    bus.i_start = 1'b0;
    bus.i_hold  = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  exp_t cur;
  bit   have_cur  = 1'b0;
  bit   in_done   = 1'b0;
  int   done_len  = 0;
  int   stall_run = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_done   = 1'b0;
      have_cur  = 1'b0;
      stall_run = 0;
    end else begin
      if (!bus.o_done) check("result_zero_when_idle", bus.o_result, 32'd0);
      if (bus.o_done) begin
        if (!in_done) begin
          check("done_expected", exp_q.size() > 0 ? 32'd1 : 32'd0, 32'd1);
          have_cur = exp_q.size() > 0;
          if (have_cur) begin
            cur = exp_q.pop_front();
            check("result", bus.o_result, cur.res);
            check("latency", cyc - cur.start, cur.lat);
            check("stall_cycles", stall_run, cur.lat);
          end
          in_done  = 1'b1;
          done_len = 1;
        end else begin
          done_len++;
          if (have_cur) check("result_stable", bus.o_result, cur.res);
        end
      end else if (in_done) begin
        if (have_cur) check("done_length", done_len, cur.len);
        in_done = 1'b0;
      end
      stall_run = bus.i_kill ? 0 : (bus.o_stall ? stall_run + 1 : 0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    muldiv_op_t  op;
    logic [31:0] a, b;
    int          k;

    rst         = 1'b1;
    bus.i_start = 1'b0;
    bus.i_op    = MD_MUL;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_kill  = 1'b0;
    bus.i_hold  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done",   {31'd0, bus.o_done},  32'd0);
    check("rst_stall",  {31'd0, bus.o_stall}, 32'd0);
    check("rst_result", bus.o_result,         32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_stall", {31'd0, bus.o_stall}, 32'd0);
    check("idle_done",  {31'd0, bus.o_done},  32'd0);
    @(posedge clk); #1;

    // Directed cases with known answers.
    do_op(MD_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 0);   // 0xFFFFFFEB
    do_op(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);   // 0xFFFFFFFE
    do_op(MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);   // 0x00000000
    do_op(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(MD_DIV,    32'hFFFF_FFF9, 32'd2,         0);   // 0xFFFFFFFD
    do_op(MD_REM,    32'hFFFF_FFF9, 32'd2,         0);   // 0xFFFFFFFF
    do_op(MD_DIVU,   32'd100,       32'd0,         0);   // fast path
    do_op(MD_REMU,   32'd100,       32'd0,         0);   // fast path, returns a
    do_op(MD_DIV,    INT_MIN,       32'hFFFF_FFFF, 0);   // overflow fast path
    do_op(MD_REM,    INT_MIN,       32'hFFFF_FFFF, 0);
    do_op(MD_DIVU,   32'hFFFF_FFFF, 32'd1,         5);   // held in DONE
    do_op(MD_REMU,   32'd12345,     32'd1000,      0);   // back-to-back start

    // Kill during CALC at T+10, new start at T+11.
    bus.i_start = 1'b1; bus.i_op = MD_DIVU; bus.i_a = 32'd1000; bus.i_b = 32'd7;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    bus.i_kill = 1'b1;
    @(posedge clk); #1;
    bus.i_kill = 1'b0;
    do_op(MD_MUL, 32'd123, 32'd456, 0);

    // Kill in the fast-path DONE cycle: no result may appear.
    bus.i_start = 1'b1; bus.i_op = MD_DIVU; bus.i_a = 32'd5; bus.i_b = 32'd0;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    bus.i_kill  = 1'b1;
    @(posedge clk); #1;
    bus.i_kill  = 1'b0;

    // Kill overrides start in IDLE.
    bus.i_start = 1'b1; bus.i_kill = 1'b1; bus.i_op = MD_MUL; bus.i_a = 32'd3; bus.i_b = 32'd4;
    @(negedge clk);
    check("kill_start_stall", {31'd0, bus.o_stall}, 32'd0);
    @(posedge clk); #1;
    bus.i_start = 1'b0; bus.i_kill = 1'b0;
    @(negedge clk);
    check("kill_start_not_taken", {31'd0, bus.o_stall}, 32'd0);
    @(posedge clk); #1;

    // Reset mid-CALC abandons the op; first cycle after reset is IDLE.
    bus.i_start = 1'b1; bus.i_op = MD_MULHU; bus.i_a = 32'hDEAD_BEEF; bus.i_b = 32'h1234_5678;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(MD_REM, 32'hFFFF_FF00, 32'd7, 1);

    // Randomised operations.
    for (int n = 0; n < 40; n++) begin
      op = muldiv_op_t'(3'($urandom_range(0, 7)));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = INT_MIN; b = 32'hFFFF_FFFF; end
        2: begin
          a = $urandom_range(0, 40);
          b = $urandom_range(1, 9);
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: ;
      endcase
      do_op(op, a, b, $urandom_range(0, 3));
    end

    // Drain: every expected result must have been seen.
    k = 0;
    while ((exp_q.size() != 0 || in_done) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
